lsm_sequencer: RTL and testbench

//  Multi-cycle sequencer for the block-transfer instructions LM, SM, LA and SA.
//  The control unit raises sig_multiple or sig_all for these opcodes; this block then expands the

---
 rtl/lsm_sequencer_pkg.sv | 14 +
 rtl/lsm_sequencer_prienc.sv | 20 ++
 rtl/lsm_sequencer.sv | 106 ++++++++++
 tb/tb_lsm_sequencer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsm_sequencer_pkg.sv
// Shared definitions for the LM/SM/LA/SA block-transfer sequencer.
package lsm_sequencer_pkg;

  localparam int LSM_ADDR_W = 16;
  localparam int LSM_NREG   = 8;
  localparam int LSM_IDX_W  = 3;

  typedef enum logic [1:0] {
    LSM_IDLE   = 2'd0,
    LSM_ACCESS = 2'd1,
    LSM_DONE   = 2'd2
  } lsm_state_e;

endpackage

// File: rtl/lsm_sequencer_prienc.sv
// Lowest-set-bit priority encoder; R0 has the highest priority.
module lsm_sequencer_prienc #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     vec_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/lsm_sequencer.sv
// Expands LM/SM/LA/SA into one register/memory transfer per cycle, stalling
// the front end until the last transfer has completed.
module lsm_sequencer
  import lsm_sequencer_pkg::*;
#(
  parameter int ADDR_W = LSM_ADDR_W,
  parameter int NREG   = LSM_NREG,
  parameter int IDX_W  = LSM_IDX_W
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic              start_i,
  input  logic              sig_multiple_i,
  input  logic              sig_all_i,
  input  logic              load_i,
  input  logic [NREG-1:0]   imm8_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              stall_in_i,
  output logic              stall_pipe_o,
  output logic [IDX_W-1:0]  reg_addr_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_read_o,
  output logic              mem_write_o,
  output logic              reg_write_o,
  output logic              done_o
);

  lsm_state_e        state_q;
  logic [NREG-1:0]   mask_q;
  logic [NREG-1:0]   mask_d;
  logic [NREG-1:0]   start_mask;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] offset_q;
  logic              load_q;
  logic              accept;
  logic              pe_valid;
  logic [IDX_W-1:0]  pe_idx;

  lsm_sequencer_prienc #(.N(NREG), .IDX_W(IDX_W)) u_prienc (
    .vec_i   (mask_q),
    .valid_o (pe_valid),
    .idx_o   (pe_idx)
  );

  assign accept     = (state_q == LSM_IDLE) && start_i && (sig_multiple_i || sig_all_i);
  assign start_mask = sig_all_i ? {NREG{1'b1}} : imm8_i;
  assign mask_d     = mask_q & ~(NREG'(1) << pe_idx);

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= LSM_IDLE;
      mask_q   <= '0;
      base_q   <= '0;
      offset_q <= '0;
      load_q   <= 1'b0;
    end else begin
      case (state_q)
        LSM_IDLE: begin
          if (accept) begin
            mask_q   <= start_mask;
            base_q   <= base_addr_i;
            offset_q <= '0;
            load_q   <= load_i;
            state_q  <= (start_mask != '0) ? LSM_ACCESS : LSM_DONE;
          end
        end
        LSM_ACCESS: begin
          // Offsets advance per completed transfer, independent of list gaps.
          if (!stall_in_i) begin
            mask_q   <= mask_d;
            offset_q <= offset_q + ADDR_W'(1);
            if (mask_d == '0) state_q <= LSM_DONE;
          end
        end
        LSM_DONE: state_q <= LSM_IDLE;
        default:  state_q <= LSM_IDLE;
      endcase
    end
  end

  always_comb begin
    stall_pipe_o = 1'b0;
    reg_addr_o   = '0;
    mem_addr_o   = '0;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;
    reg_write_o  = 1'b0;
    done_o       = 1'b0;
    case (state_q)
      // The accept cycle must already freeze the front end; gate with reset
      // so every output reads 0 while reset is held.
      LSM_IDLE: stall_pipe_o = accept && reset_ni;
      LSM_ACCESS: begin
        stall_pipe_o = 1'b1;
        reg_addr_o   = pe_valid ? pe_idx : '0;
        mem_addr_o   = base_q + offset_q;
        mem_read_o   = load_q;
        mem_write_o  = !load_q;
        reg_write_o  = load_q && !stall_in_i;
      end
      LSM_DONE: done_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsm_sequencer.sv
// Bench for lsm_sequencer: directed table, reset corner case and randomized
// transactions checked cycle by cycle against a transfer-list model.
module tb_lsm_sequencer;

  logic        clk = 1'b0;
  logic        reset_ni;
  logic        start;
  logic        sig_m;
  logic        sig_a;
  logic        load;
  logic [7:0]  imm8;
  logic [15:0] base_addr;
  logic        stall_in;
  logic        stall_pipe;
  logic [2:0]  reg_addr;
  logic [15:0] mem_addr;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        done;

  int checks = 0;
  int failures = 0;

  int          obs_n, obs_rw, obs_stall, obs_done_at, obs_cyc;
  logic [2:0]  obs_last_r;
  logic [15:0] obs_last_a;

  lsm_sequencer dut (
    .clk_i          (clk),
    .reset_ni       (reset_ni),
    .start_i        (start),
    .sig_multiple_i (sig_m),
    .sig_all_i      (sig_a),
    .load_i         (load),
    .imm8_i         (imm8),
    .base_addr_i    (base_addr),
    .stall_in_i     (stall_in),
    .stall_pipe_o   (stall_pipe),
    .reg_addr_o     (reg_addr),
    .mem_addr_o     (mem_addr),
    .mem_read_o     (mem_read),
    .mem_write_o    (mem_write),
    .reg_write_o    (reg_write),
    .done_o         (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sm, sa, ld;
    logic [7:0]  imm;
    logic [15:0] base;
    int          stall_k, stall_len;
    bit          spur;
    int          e_n, e_rw, e_stall, e_done;
    logic [2:0]  e_last_r;
    logic [15:0] e_last_a;
  } vec_t;

  vec_t tbl[6];

  // Packed view: {stall_pipe, reg_addr, mem_addr, mem_read, mem_write, reg_write, done}
  function automatic logic [23:0] pk(input logic sp, input logic [2:0] ra, input logic [15:0] ma,
                                     input logic rd, input logic wr, input logic rw, input logic dn);
    return {sp, ra, ma, rd, wr, rw, dn};
  endfunction

  task automatic check_vec(input string name, input logic [23:0] exp);
    logic [23:0] got;
    got = {stall_pipe, reg_addr, mem_addr, mem_read, mem_write, reg_write, done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, obs_cyc, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", name, got, exp);
    end
  endtask

  // Sample mid-cycle, record what the DUT did, then return to posedge+1.
  task automatic step(input string name, input logic [23:0] exp);
    @(negedge clk);
    check_vec(name, exp);
    if ((mem_read || mem_write) && !stall_in) begin
      obs_n++;
      obs_last_r = reg_addr;
      obs_last_a = mem_addr;
    end
    if (reg_write) obs_rw++;
    if (stall_pipe) obs_stall++;
    if (done && obs_done_at < 0) obs_done_at = obs_cyc;
    obs_cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic spurious(input bit en);
    if (en) begin
      start     = 1'($urandom);
      sig_m     = 1'($urandom);
      sig_a     = 1'($urandom);
      load      = 1'($urandom);
      imm8      = 8'($urandom);
      base_addr = 16'($urandom);
    end else begin
      start = 1'b0;
    end
  endtask

  // One instruction: expected outputs come from the list of selected
  // registers, each placed at base + (position in the list).
  task automatic do_seq(input string name, input logic sm, input logic sa, input logic ld,
                        input logic [7:0] imm, input logic [15:0] base,
                        input int stall_k, input int stall_len, input bit rnd_stall, input bit spur);
    int regs[$];
    logic [7:0] eff;
    logic st;
    int s;
    obs_n = 0; obs_rw = 0; obs_stall = 0; obs_done_at = -1; obs_cyc = 0;
    obs_last_r = '0; obs_last_a = '0;
    eff = sa ? 8'hFF : imm;
    for (int i = 0; i < 8; i++) if (eff[i]) regs.push_back(i);
    start = 1'b1; sig_m = sm; sig_a = sa; load = ld; imm8 = imm; base_addr = base; stall_in = 1'b0;
    step(name, pk(1'b1, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    for (int k = 0; k < regs.size(); k++) begin
      s = 0;
      forever begin
        st = (k == stall_k && s < stall_len) || (rnd_stall && s < 4 && $urandom_range(3) == 0);
        stall_in = st;
        spurious(spur);
        step(name, pk(1'b1, 3'(regs[k]), base + 16'(k), ld, !ld, ld && !st, 1'b0));
        s++;
        if (!st) break;
      end
    end
    stall_in = 1'($urandom);
    spurious(spur);
    step(name, pk(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b1));
    start = 1'b0; stall_in = 1'b0;
    step(name, pk(1'b0, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
  endtask

  initial begin
    logic [23:0] zero;
    zero = '0;
    reset_ni = 1'b0; start = 1'b0; sig_m = 1'b0; sig_a = 1'b0; load = 1'b0;
    imm8 = '0; base_addr = '0; stall_in = 1'b0;
    obs_cyc = 0;

    // Directed table: LM A5, SA wrap, SM empty, LM with stall, both sigs + spurious start, LM wrap with gap
    tbl[0] = '{1'b1, 1'b0, 1'b1, 8'hA5, 16'h0040, -1, 0, 1'b0, 4, 4, 5, 5, 3'd7, 16'h0043};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 8'h12, 16'hFFFE, -1, 0, 1'b0, 8, 0, 9, 9, 3'd7, 16'h0005};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 16'h1234, -1, 0, 1'b0, 0, 0, 1, 1, 3'd0, 16'h0000};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 8'h03, 16'h0100, 1, 3, 1'b0, 2, 2, 6, 6, 3'd1, 16'h0101};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'h01, 16'h0200, -1, 0, 1'b1, 8, 8, 9, 9, 3'd7, 16'h0207};
    tbl[5] = '{1'b1, 1'b0, 1'b1, 8'h90, 16'hFFFF, -1, 0, 1'b0, 2, 2, 3, 3, 3'd7, 16'h0000};

    #12;
    check_vec("reset_outputs", zero);
    start = 1'b1; sig_a = 1'b1;
    #1;
    check_vec("reset_start_gated", zero);
    start = 1'b0; sig_a = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk);
    #1;

    for (int t = 0; t < 6; t++) begin
      do_seq($sformatf("tbl%0d", t), tbl[t].sm, tbl[t].sa, tbl[t].ld, tbl[t].imm, tbl[t].base,
             tbl[t].stall_k, tbl[t].stall_len, 1'b0, tbl[t].spur);
      check_int($sformatf("tbl%0d_xfers", t), obs_n, tbl[t].e_n);
      check_int($sformatf("tbl%0d_regwrites", t), obs_rw, tbl[t].e_rw);
      check_int($sformatf("tbl%0d_stall_cycles", t), obs_stall, tbl[t].e_stall);
      check_int($sformatf("tbl%0d_done_at", t), obs_done_at, tbl[t].e_done);
      check_int($sformatf("tbl%0d_last_reg", t), int'(obs_last_r), int'(tbl[t].e_last_r));
      check_int($sformatf("tbl%0d_last_addr", t), int'(obs_last_a), int'(tbl[t].e_last_a));
      $display("txn tbl%0d xfers=%0d regwrites=%0d stall=%0d done_at=%0d", t, obs_n, obs_rw, obs_stall, obs_done_at);
    end

    // Reset in the middle of an LA after three transfers.
    obs_cyc = 0;
    start = 1'b1; sig_m = 1'b0; sig_a = 1'b1; load = 1'b1; base_addr = 16'h0300; stall_in = 1'b0;
    step("midreset_accept", pk(1'b1, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0));
    start = 1'b0;
    for (int k = 0; k < 3; k++)
      step("midreset_xfer", pk(1'b1, 3'(k), 16'h0300 + 16'(k), 1'b1, 1'b0, 1'b1, 1'b0));
    #2;
    reset_ni = 1'b0;
    #1;
    check_vec("midreset_immediate", zero);
    start = 1'b1; sig_a = 1'b1;
    for (int k = 0; k < 3; k++) step("midreset_held", zero);
    start = 1'b0; sig_a = 1'b0;
    @(negedge clk);
    reset_ni = 1'b1;
    @(posedge clk);
    #1;
    do_seq("after_reset", 1'b1, 1'b0, 1'b1, 8'h80, 16'h0500, -1, 0, 1'b0, 1'b0);
    check_int("after_reset_xfers", obs_n, 1);
    check_int("after_reset_last_reg", int'(obs_last_r), 7);
    check_int("after_reset_last_addr", int'(obs_last_a), 16'h0500);
    $display("txn after_reset xfers=%0d reg=%0d addr=%h", obs_n, obs_last_r, obs_last_a);

    // Randomized transactions with random stalls, ignored starts and spurious starts.
    for (int t = 0; t < 40; t++) begin
      int mode;
      if ($urandom_range(3) == 0) begin
        obs_cyc = 0;
        start = 1'b1; sig_m = 1'b0; sig_a = 1'b0; imm8 = 8'($urandom);
        step("ignored_start", zero);
        start = 1'b0;
      end
      mode = $urandom_range(2);
      do_seq($sformatf("rnd%0d", t), mode != 1, mode != 0, 1'($urandom), 8'($urandom),
             16'($urandom), -1, 0, 1'b1, 1'($urandom));
      $display("txn rnd%0d mode=%0d xfers=%0d regwrites=%0d done_at=%0d", t, mode, obs_n, obs_rw, obs_done_at);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
